// File: rtl/rr_arbiter_ctrl.sv
// Four-requester round-robin arbiter with a bounded hold time, a forced-release
// timeout pulse and a mandatory one-cycle gap between grants.
module rr_arbiter_ctrl #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout,
    output logic [1:0] timeout_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [7:0] hold_cnt, hold_cnt_nxt;
    logic [3:0] gnt_nxt;
    logic [1:0] gnt_id_nxt;
    logic       busy_nxt;
    logic       timeout_nxt;
    logic [1:0] timeout_id_nxt;

    logic       found;
    logic [1:0] winner;
    logic       cur_done;
    logic       cur_req;
    logic       hold_last;
    logic       release_now;
    logic       forced;

    // Search upward from ptr, wrapping 3 -> 0; first requester found wins.
    always_comb begin : pick
        logic [1:0] idx;
        found  = 1'b0;
        winner = ptr;
        idx    = ptr;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign cur_done    = done[gnt_id];
    assign cur_req     = req[gnt_id];
    assign hold_last   = (hold_cnt == 8'(MAX_HOLD - 1));
    assign release_now = cur_done || !cur_req || hold_last;
    // Timeout only when the hold limit is the sole reason for the release.
    assign forced      = hold_last && !cur_done && cur_req;

    always_ff @(posedge clk) begin
        if (rst_) begin
            state      <= IDLE;
            ptr        <= 2'd0;
            hold_cnt   <= 8'd0;
            gnt        <= 4'd0;
            gnt_id     <= 2'd0;
            busy       <= 1'b0;
            timeout    <= 1'b0;
            timeout_id <= 2'd0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            hold_cnt   <= hold_cnt_nxt;
            gnt        <= gnt_nxt;
            gnt_id     <= gnt_id_nxt;
            busy       <= busy_nxt;
            timeout    <= timeout_nxt;
            timeout_id <= timeout_id_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = GRANT;
            GRANT:   if (release_now) state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ptr_nxt        = ptr;
        hold_cnt_nxt   = hold_cnt;
        gnt_nxt        = gnt;
        gnt_id_nxt     = gnt_id;
        busy_nxt       = busy;
        timeout_nxt    = 1'b0;
        timeout_id_nxt = timeout_id;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt      = 4'b0001 << winner;
                    gnt_id_nxt   = winner;
                    busy_nxt     = 1'b1;
                    hold_cnt_nxt = 8'd0;
                    ptr_nxt      = winner + 2'd1;
                end else begin
                    gnt_nxt  = 4'd0;
                    busy_nxt = 1'b0;
                end
            end
            GRANT: begin
                hold_cnt_nxt = hold_cnt + 8'd1;
                if (release_now) begin
                    gnt_nxt  = 4'd0;
                    busy_nxt = 1'b0;
                    if (forced) begin
                        timeout_nxt    = 1'b1;
                        timeout_id_nxt = gnt_id;
                    end
                end
            end
            default: begin
                gnt_nxt  = 4'd0;
                busy_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// Directed bench for rr_arbiter_ctrl: a grant-ownership model checked every
// cycle, plus literal grant order, grant lengths and timeout ids.
module tb_rr_arbiter_ctrl;

    localparam int MAX_HOLD = 16;

    logic       clk;
    logic       rst_;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] done_man;
    logic [3:0] done_auto;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;
    logic [1:0] timeout_id;

    int n_checks = 0;
    int n_err    = 0;

    assign done = done_man | done_auto;

    rr_arbiter_ctrl #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst_       (rst_),
        .req        (req),
        .done       (done),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .busy       (busy),
        .timeout    (timeout),
        .timeout_id (timeout_id)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: who owns the bus, for how long, and how many idle edges remain
    // before arbitration is allowed again.
    int       m_owner = -1;
    int       m_len   = 0;
    int       m_cool  = 0;
    int       m_ptr   = 0;
    int       m_gid   = 0;
    int       m_tid   = 0;
    bit       m_to    = 0;
    bit       m_d, m_r, m_found;

    always @(posedge clk) begin
        m_to = 0;
        if (rst_) begin
            m_owner = -1; m_len = 0; m_cool = 0; m_ptr = 0; m_gid = 0; m_tid = 0;
        end else if (m_owner >= 0) begin
            m_d = done[m_owner];
            m_r = req[m_owner];
            if (m_d || !m_r || m_len == MAX_HOLD) begin
                if (!m_d && m_r) begin
                    m_to  = 1;
                    m_tid = m_owner;
                end
                m_owner = -1;
                m_cool  = 1;
            end else begin
                m_len++;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (req != 4'd0) begin
            m_found = 0;
            for (int k = 0; k < 4; k++) begin
                if (!m_found && req[(m_ptr + k) % 4]) begin
                    m_found = 1;
                    m_owner = (m_ptr + k) % 4;
                end
            end
            m_len = 1;
            m_gid = m_owner;
            m_ptr = (m_owner + 1) % 4;
        end
    end

    // Reactive done driver: assert done of the owner in its Nth grant cycle.
    int auto_done_at = 0;
    always @(negedge clk) begin
        if (auto_done_at > 0 && m_owner >= 0 && m_len == auto_done_at)
            done_auto = 4'(1 << m_owner);
        else
            done_auto = 4'd0;
    end

    // scoreboard: literal grant order, grant lengths, timeout ids
    logic [3:0] exp_q[$];
    int         len_q[$];
    logic [1:0] to_q[$];
    logic [3:0] prev_gnt = 4'd0;
    int         run_len  = 0;
    logic [3:0] m_gnt;

    always @(negedge clk) begin
        m_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
        chk("gnt", gnt, m_gnt);
        chk("busy", busy, (m_owner >= 0));
        chk("timeout", timeout, m_to);
        chk("gnt_onehot", ($countones(gnt) <= 1), 1);
        if (m_owner >= 0) chk("gnt_id", gnt_id, m_gid);
        if (m_to) chk("timeout_id", timeout_id, m_tid);

        if (gnt != 4'd0 && prev_gnt == 4'd0) begin
            if (exp_q.size() == 0) chk("grant_unexpected", gnt, 0);
            else chk("grant_order", gnt, exp_q.pop_front());
        end
        if (gnt == 4'd0 && prev_gnt != 4'd0) begin
            if (len_q.size() == 0) chk("grant_len_unexpected", run_len, 0);
            else chk("grant_len", run_len, len_q.pop_front());
        end
        if (timeout) begin
            if (to_q.size() == 0) chk("timeout_unexpected", timeout_id, 4);
            else chk("timeout_id_lit", timeout_id, to_q.pop_front());
        end
        run_len  = (gnt != 4'd0) ? run_len + 1 : 0;
        prev_gnt = gnt;
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_gnt(input logic [3:0] val, input string name);
        for (int i = 0; i < 60 && gnt != val; i++) step();
        chk(name, gnt, val);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 80 && (exp_q.size() != 0 || len_q.size() != 0); i++) step();
        chk(name, exp_q.size() + len_q.size(), 0);
    endtask

    initial begin
        rst_     = 1'b1;
        req      = 4'b1111;
        done_man = 4'd0;

        // reset held 3 cycles with all requesting
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_gnt", gnt, 4'd0);
            chk("rst_busy", busy, 0);
            chk("rst_timeout", timeout, 0);
        end

        // round robin: done in 3rd grant cycle -> 0,1,2,3,0 each 3 long
        auto_done_at = 3;
        exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        len_q = '{3, 3, 3, 3, 3};
        rst_  = 1'b0;
        step();
        chk("first_gnt", gnt, 4'b0001);
        chk("first_gnt_id", gnt_id, 0);
        wait_drain("rr_drain");
        req          = 4'd0;
        auto_done_at = 0;
        step();
        step();
        chk("rr_idle_gnt", gnt, 4'd0);

        // timeout: lone requester 2 held 16 cycles, pulse id 2, re-granted
        exp_q = '{4'b0100, 4'b0100};
        len_q = '{16, 16};
        to_q  = '{2'd2};
        req   = 4'b0100;
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) step();
        chk("to_regrant", exp_q.size(), 0);
        chk("to_pulses_seen", to_q.size(), 0);

        // coincident done with the hold limit: normal release, no timeout
        auto_done_at = 16;
        wait_drain("coinc_drain");
        req          = 4'd0;
        auto_done_at = 0;
        step();
        step();
        chk("coinc_no_timeout", timeout, 0);

        // req drop of requester 1 in its 5th cycle, requester 3 waiting
        exp_q = '{4'b0010, 4'b1000};
        len_q = '{5, 1};
        req   = 4'b0010;
        wait_gnt(4'b0010, "drop_gnt1");
        done_man = 4'b1101;
        step(); step(); step();
        done_man = 4'd0;
        step();
        req = 4'b1000;
        step();
        chk("drop_gnt_zero", gnt, 4'd0);
        chk("drop_no_timeout", timeout, 0);
        wait_gnt(4'b1000, "drop_next_gnt");
        req = 4'd0;
        wait_drain("drop_drain");

        // reset in grant cycle 4 of requester 2
        exp_q = '{4'b0100, 4'b0001};
        len_q = '{4, 1};
        req   = 4'b0100;
        wait_gnt(4'b0100, "rstmid_gnt2");
        step(); step(); step();
        rst_ = 1'b1;
        req  = 4'b0101;
        step();
        chk("rstmid_gnt", gnt, 4'd0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_timeout", timeout, 0);
        rst_ = 1'b0;
        step();
        chk("rstmid_next_gnt", gnt, 4'b0001);
        chk("rstmid_next_id", gnt_id, 0);
        req = 4'd0;
        wait_drain("rstmid_drain");
        step(); step();
        chk("final_to_q", to_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_ctrl.md
RR_ARBITER_CTRL -- requirements
Module: rr_arbiter_ctrl

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, maximum consecutive grant cycles per requester (legal range 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req  input  4  per-requester request, level, bit i = requester i.
REQ-005 SHALL have port done  input  4  per-requester release; bit i sampled only while gnt[i]=1.
REQ-006 SHALL have port gnt  output  4  registered grant, one-hot or zero.
REQ-007 SHALL have port gnt_id  output  2  index of the current grant; valid only while busy=1.
REQ-008 SHALL have port busy  output  1  registered, high exactly when gnt != 0.
REQ-009 SHALL have port timeout  output  1  registered one-cycle pulse on forced release.
REQ-010 SHALL have port timeout_id  output  2  index of the requester forced off; valid while timeout=1.

Function
REQ-011 SHALL implement FSM states IDLE, GRANT and GAP; all outputs SHALL be registered.
REQ-012 In IDLE with req != 0, the block SHALL, on the next edge, enter GRANT, set gnt to one-hot(winner), set gnt_id=winner and busy=1, and clear hold_cnt.
REQ-013 In IDLE with req == 0, the block SHALL remain in IDLE with gnt=0.
REQ-014 The winner SHALL be the first requester with req set, searching upward from ptr and wrapping 3->0.
REQ-015 On each grant, ptr SHALL update to (winner+1) mod 4, so 3 wraps to 0.
REQ-016 In GRANT, hold_cnt SHALL increment by 1 per cycle as an 8-bit counter that never wraps within the legal range.
REQ-017 In GRANT, release SHALL occur on the edge where done[gnt_id]=1, or req[gnt_id]=0, or hold_cnt==MAX_HOLD-1.
REQ-018 On release, the block SHALL go to GAP with gnt=0 and busy=0.
REQ-019 gnt SHALL therefore be high for at most MAX_HOLD consecutive cycles.
REQ-020 timeout SHALL pulse for one cycle, coincident with the first GAP cycle, with timeout_id=gnt_id, only when release is caused solely by hold_cnt==MAX_HOLD-1.
REQ-021 If done or a req drop coincides with hold_cnt==MAX_HOLD-1, the block SHALL release normally and timeout SHALL stay 0.
REQ-022 GAP SHALL last exactly one cycle with gnt=0 and SHALL then go to IDLE; the minimum gap between two grants is 2 cycles with gnt=0.
REQ-023 done bits of non-granted requesters SHALL be ignored.
REQ-024 req changes of non-granted requesters SHALL not affect the current grant.
REQ-025 A requester forced off by timeout that still requests SHALL be re-arbitrated normally, lowest priority after the ptr update.
REQ-026 gnt SHALL never have more than one bit set.

Reset
REQ-027 While rst_=1 at an edge, the block SHALL set state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, timeout_id=0, ptr=0 and hold_cnt=0, regardless of req or done.
REQ-028 Reset asserted during GRANT SHALL clear gnt on that edge with no timeout pulse.
REQ-029 The first edge with rst_=0 SHALL perform a normal IDLE arbitration from ptr=0.

Verification
REQ-030 Bench SHALL cover reset: rst_=1 for 3 cycles with req=4'b1111 -> gnt=0, busy=0, timeout=0 throughout; first edge after rst_=0 -> gnt=4'b0001, gnt_id=0.
REQ-031 Bench SHALL cover round-robin: req=4'b1111 held, each granted requester asserts done in its 3rd grant cycle -> grant order 0,1,2,3,0, each gnt high 3 cycles, 2 zero cycles between grants, timeout never set.
REQ-032 Bench SHALL cover timeout: MAX_HOLD=16, req=4'b0100 held, done=0 -> gnt=4'b0100 for exactly 16 cycles, then timeout=1 for 1 cycle with timeout_id=2, then gnt=4'b0100 again after 2 zero cycles.
REQ-033 Bench SHALL cover coincident done and timeout: done[gnt_id]=1 in grant cycle 16 with MAX_HOLD=16 -> release after 16 cycles, timeout=0.
REQ-034 Bench SHALL cover req drop: requester 1 granted, req[1] dropped in its 5th grant cycle with req[3]=1 -> gnt=0 on the next edge, timeout=0, next grant 4'b1000.
REQ-035 Bench SHALL cover reset mid-grant: rst_=1 in grant cycle 4 of requester 2 -> gnt=0 and busy=0 on that edge, no timeout, ptr=0, so the next grant goes to the lowest-index requester.
